regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised successor to the processor's 32x32 register file.
- Width and depth are configurable. Register 0 can optionally be hardwired to zero. An optional write-to-read bypass is provided.
- A sequenced bulk-clear engine (one entry per cycle) lets the core wipe architectural state without asserting global reset.
- Sits between decode (read addresses) and writeback (write port) in the 5-stage pipeline.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port; 0 = reads show stored contents only.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- ctrl_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ctrl_writeEnable  input  1  write strobe, sampled at the rising edge.
- ctrl_writeReg  input  ADDR_WIDTH  write address.
- data_writeReg  input  DATA_WIDTH  write data.
- ctrl_readRegA  input  ADDR_WIDTH  read port A address.
- ctrl_readRegB  input  ADDR_WIDTH  read port B address.
- data_readRegA  output  DATA_WIDTH  read port A data.
- data_readRegB  output  DATA_WIDTH  read port B data.
- ctrl_clear  input  1  request a bulk clear of all entries.
- clear_busy  output  1  high while the clear sweep is in progress.
- write_dropped  output  1  registered one-cycle pulse: a write was discarded.

Behaviour:
- Reset:
  - ctrl_reset=0 immediately zeroes all entries, FSM goes to IDLE, ptr=0, clear_busy=0, write_dropped=0.
  - Deassertion takes effect asynchronously; the first write is accepted on the first rising edge after deassertion.
- Reads:
  - Combinational, zero latency; both ports are independent and may use the same address.
  - ZERO_REG=1 and address 0: output is 0.
  - BYPASS=1, FSM in IDLE, ctrl_writeEnable=1, and read address equals ctrl_writeReg (not the zero reg): output = data_writeReg. Otherwise output = stored entry.
- Writes (IDLE):
  - On the rising edge with ctrl_writeEnable=1, entry[ctrl_writeReg] <= data_writeReg.
  - A write to entry 0 with ZERO_REG=1 is ignored silently; no write_dropped pulse.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: ctrl_clear=1 at the edge -> CLEAR, ptr=0, clear_busy=1 from the next cycle.
    - A write presented in that same cycle is performed first; it is then cleared by the sweep.
  - CLEAR: at each edge entry[ptr] <= 0 and ptr <= ptr+1.
    - At ptr=DEPTH-1, clear that entry, go to IDLE, ptr wraps to 0.
    - The sweep occupies DEPTH cycles with clear_busy=1.
  - In CLEAR, ctrl_writeEnable=1 means the write is discarded and write_dropped=1 on the next cycle. Exception: a ZERO_REG entry-0 write is not reported.
  - ctrl_clear in CLEAR is ignored; it does not restart the sweep.
  - In CLEAR, bypass is disabled. Reads return stored values, so already-swept entries read 0 and unswept entries keep their old value.
  - Asserting ctrl_reset mid-sweep aborts the sweep: immediate IDLE, everything zeroed.
- Width rules:
  - Addresses are exactly ADDR_WIDTH bits, so no out-of-range address exists.
  - ptr is ADDR_WIDTH bits; its wrap from DEPTH-1 to 0 is the termination condition.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=5, ZERO_REG=1, BYPASS=1 unless noted):
1. Reset, then write 0xDEADBEEF to r7 and read A=7, B=7 in the next cycle -> both 0xDEADBEEF. Write 0x1234 to r0 -> r0 reads 0, write_dropped stays 0.
2. Bypass: r3 holds 0x11; in the same cycle write 0x22 to r3 and read A=3 -> A=0x22 combinationally. Repeat with BYPASS=0 -> A=0x11, then 0x22 after the edge.
3. Fill r1..r31 with value=index. Pulse ctrl_clear -> clear_busy high for exactly 32 cycles. Mid-sweep, read r20 at ptr=10 -> 20; read r5 -> 0. After the sweep all reads return 0.
4. Write r9=0xAA during CLEAR -> write_dropped pulses one cycle; r9 reads 0 after the sweep. Re-pulse ctrl_clear at ptr=15 -> the sweep still ends 32 cycles after the original start.
5. Start a clear, assert ctrl_reset at ptr=12 -> clear_busy=0 immediately, all reads 0. After release, write r4=0x5 -> r4 reads 0x5 next cycle.
6. ZERO_REG=0, DATA_WIDTH=16, ADDR_WIDTH=3: write r0=0xBEEF -> r0 reads 0xBEEF. A clear takes 8 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file with optional zero register, optional
// write-to-read bypass and a one-entry-per-cycle bulk-clear sweep.
module regfile_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_clear,
    output logic                  clear_busy,
    output logic                  write_dropped
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic                  drop_q, drop_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic wr_zero_c;
    logic bypass_en_c;

    // Writes aimed at the hardwired zero register are neither stored nor reported.
    assign wr_zero_c   = ZERO_REG && (ctrl_writeReg == '0);
    assign bypass_en_c = BYPASS && (state_q == S_IDLE) && ctrl_writeEnable;

    // State, pointer, storage and status flops; reset wipes everything.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
        end
    end

    // Next-state: normal writes in IDLE, one entry zeroed per cycle in CLEAR.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        drop_d  = 1'b0;
        mem_d   = mem_q;
        unique case (state_q)
            S_IDLE: begin
                // A write coinciding with the clear request lands first, then gets swept.
                if (ctrl_writeEnable && !wr_zero_c) begin
                    mem_d[ctrl_writeReg] = data_writeReg;
                end
                if (ctrl_clear) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ADDR_WIDTH'(ptr_q + 1'b1);
                if (ptr_q == LAST_PTR) begin
                    state_d = S_IDLE;
                end
                if (ctrl_writeEnable && !wr_zero_c) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // Read port A: zero register, then bypass, then stored contents.
    always_comb begin
        data_readRegA = mem_q[ctrl_readRegA];
        if (ZERO_REG && (ctrl_readRegA == '0)) begin
            data_readRegA = '0;
        end else if (bypass_en_c && (ctrl_readRegA == ctrl_writeReg)) begin
            data_readRegA = data_writeReg;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        data_readRegB = mem_q[ctrl_readRegB];
        if (ZERO_REG && (ctrl_readRegB == '0)) begin
            data_readRegB = '0;
        end else if (bypass_en_c && (ctrl_readRegB == ctrl_writeReg)) begin
            data_readRegB = data_writeReg;
        end
    end

    assign clear_busy    = busy_q;
    assign write_dropped = drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param in three configurations.
module tb_regfile_param;

    logic        clock;
    logic        ctrl_reset;

    logic        we, clr;
    logic [4:0]  wa, ra, rb;
    logic [31:0] wd;
    logic [31:0] rd_a, rd_b, nb_a, nb_b;
    logic        busy, drop, nb_busy, nb_drop;

    logic        s_we, s_clr;
    logic [2:0]  s_wa, s_ra, s_rb;
    logic [15:0] s_wd, s_a, s_b;
    logic        s_busy, s_drop;

    int n_checks = 0;
    int n_errors = 0;
    int k;

    regfile_param u_dut (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(rd_a), .data_readRegB(rd_b),
        .ctrl_clear(clr), .clear_busy(busy), .write_dropped(drop)
    );

    regfile_param #(.BYPASS(1'b0)) u_nb (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wa), .data_writeReg(wd),
        .ctrl_readRegA(ra), .ctrl_readRegB(rb),
        .data_readRegA(nb_a), .data_readRegB(nb_b),
        .ctrl_clear(clr), .clear_busy(nb_busy), .write_dropped(nb_drop)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) u_sm (
        .clock(clock), .ctrl_reset(ctrl_reset),
        .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wa), .data_writeReg(s_wd),
        .ctrl_readRegA(s_ra), .ctrl_readRegB(s_rb),
        .data_readRegA(s_a), .data_readRegB(s_b),
        .ctrl_clear(s_clr), .clear_busy(s_busy), .write_dropped(s_drop)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        clock = 1'b0; ctrl_reset = 1'b0;
        we = 1'b0; clr = 1'b0; wa = '0; ra = '0; rb = '0; wd = '0;
        s_we = 1'b0; s_clr = 1'b0; s_wa = '0; s_ra = '0; s_rb = '0; s_wd = '0;

        // Reset state
        repeat (2) @(negedge clock);
        ra = 5'd7; rb = 5'd31;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_drop", 32'(drop), 32'd0);
        check_eq("rst_rd_a", rd_a, 32'd0);
        check_eq("rst_rd_b", rd_b, 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b1;

        // Test 1: basic write/read, zero register
        we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF;
        @(negedge clock);
        we = 1'b0; ra = 5'd7; rb = 5'd7;
        #1;
        check_eq("t1_r7_a", rd_a, 32'hDEADBEEF);
        check_eq("t1_r7_b", rd_b, 32'hDEADBEEF);
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = 5'd0;
        #1;
        check_eq("t1_r0_nobyp", rd_a, 32'd0);
        @(negedge clock);
        we = 1'b0;
        #1;
        check_eq("t1_r0_read", rd_a, 32'd0);
        check_eq("t1_r0_drop", 32'(drop), 32'd0);

        // Test 2: bypass on, bypass off
        we = 1'b1; wa = 5'd3; wd = 32'h11;
        @(negedge clock);
        wd = 32'h22; ra = 5'd3;
        #1;
        check_eq("t2_byp", rd_a, 32'h22);
        check_eq("t2_nobyp_old", nb_a, 32'h11);
        @(negedge clock);
        we = 1'b0;
        #1;
        check_eq("t2_nobyp_new", nb_a, 32'h22);
        check_eq("t2_byp_stored", rd_a, 32'h22);

        // Test 3: fill, sweep length, mid-sweep reads, all zero after
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i);
            @(negedge clock);
        end
        we = 1'b0; clr = 1'b1;
        @(negedge clock);
        clr = 1'b0; k = 0;
        while (busy && k < 100) begin
            if (k == 10) begin
                ra = 5'd20; rb = 5'd5;
                #1;
                check_eq("t3_mid_r20", rd_a, 32'd20);
                check_eq("t3_mid_r5", rd_b, 32'd0);
            end
            @(negedge clock);
            k++;
        end
        check_eq("t3_len", 32'(k), 32'd32);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            #1;
            check_eq("t3_after_zero", rd_a, 32'd0);
        end

        // Test 4: write with clear, dropped writes, ignored re-clear
        we = 1'b1; wa = 5'd9; wd = 32'h77; clr = 1'b1;
        @(negedge clock);
        we = 1'b0; clr = 1'b0; k = 0;
        while (busy && k < 100) begin
            if (k == 2) begin
                we = 1'b1; wa = 5'd9; wd = 32'hAA; ra = 5'd9;
                #1;
                check_eq("t4_clear_nobyp", rd_a, 32'h77);
            end
            if (k == 3) begin
                we = 1'b0;
                #1;
                check_eq("t4_drop_pulse", 32'(drop), 32'd1);
            end
            if (k == 4) begin
                #1;
                check_eq("t4_drop_end", 32'(drop), 32'd0);
                we = 1'b1; wa = 5'd0; wd = 32'h55;
            end
            if (k == 5) we = 1'b0;
            if (k == 6) begin
                #1;
                check_eq("t4_r0_nodrop", 32'(drop), 32'd0);
            end
            if (k == 15) clr = 1'b1;
            if (k == 16) clr = 1'b0;
            @(negedge clock);
            k++;
        end
        check_eq("t4_len", 32'(k), 32'd32);
        ra = 5'd9;
        #1;
        check_eq("t4_r9_zero", rd_a, 32'd0);

        // Test 5: reset aborts the sweep
        we = 1'b1; wa = 5'd20; wd = 32'h55;
        @(negedge clock);
        wa = 5'd25; wd = 32'h66;
        @(negedge clock);
        we = 1'b0; clr = 1'b1;
        @(negedge clock);
        clr = 1'b0; k = 0;
        while (busy && k < 12) begin
            @(negedge clock);
            k++;
        end
        check_eq("t5_reach_12", 32'(k), 32'd12);
        ra = 5'd20; rb = 5'd25;
        #1;
        check_eq("t5_pre_r20", rd_a, 32'h55);
        ctrl_reset = 1'b0;
        #1;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_r20", rd_a, 32'd0);
        check_eq("t5_r25", rd_b, 32'd0);
        @(negedge clock);
        ctrl_reset = 1'b1;
        we = 1'b1; wa = 5'd4; wd = 32'h5;
        @(negedge clock);
        we = 1'b0; ra = 5'd4;
        #1;
        check_eq("t5_r4", rd_a, 32'h5);
        check_eq("t5_idle", 32'(busy), 32'd0);

        // Test 6: small instance, ordinary r0, 8-cycle clear
        s_we = 1'b1; s_wa = 3'd0; s_wd = 16'hBEEF; s_ra = 3'd0;
        #1;
        check_eq("t6_r0_byp", 32'(s_a), 32'h0000BEEF);
        @(negedge clock);
        s_we = 1'b0;
        #1;
        check_eq("t6_r0_stored", 32'(s_a), 32'h0000BEEF);
        s_clr = 1'b1;
        @(negedge clock);
        s_clr = 1'b0; k = 0;
        while (s_busy && k < 100) begin
            @(negedge clock);
            k++;
        end
        check_eq("t6_len", 32'(k), 32'd8);
        #1;
        check_eq("t6_r0_zero", 32'(s_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
